// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the DRAM-port block arbiter.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package mem_arb_pkg;

  // Controller states: wait for a request, run one DRAM transfer, pulse the acknowledge.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    XFER = 2'd1,
    RESP = 2'd2
  } arb_state_e;

  // Arbitration policy selector.
  typedef enum logic {
    ARB_RR    = 1'b0,
    ARB_FIXED = 1'b1
  } arb_mode_e;

  // Default memory geometry, matching the DRAM controller build.
  localparam int DEF_ADDR_W      = 32;
  localparam int DEF_WORD_W      = 32;
  localparam int DEF_BLOCK_WORDS = 4;

  // One DRAM block at the default geometry; word 0 is the least significant word.
  typedef logic [DEF_BLOCK_WORDS-1:0][DEF_WORD_W-1:0] block_t;

  // Circular index step used by the round-robin search; base is always < n.
  function automatic int wrap_index(input int base, input int offset, input int n);
    return (base + offset) % n;
  endfunction

endpackage

// File: rtl/mem_port_arbiter_rr_pick.sv
// Combinational winner selection among the requesting ports.
// Latency: zero cycles, purely combinational.
// Backpressure: none; the caller decides when the result is used.
module rr_pick
  import mem_arb_pkg::*;
#(
  parameter  int NUM_PORTS = 2,
  localparam int ID_W      = $clog2(NUM_PORTS)
) (
  input  logic [NUM_PORTS-1:0] request,
  input  logic [ID_W-1:0]      last_grant,
  input  arb_mode_e            mode,
  output logic [ID_W-1:0]      winner,
  output logic                 valid
);

  // Scan from the lowest-priority candidate upward so the highest-priority hit is written last.
  always_comb begin
    int idx;
    idx    = 0;
    winner = '0;
    valid  = |request;
    if (mode == ARB_FIXED) begin
      for (int i = NUM_PORTS - 1; i >= 0; i--) begin
        if (request[i]) begin
          winner = ID_W'(i);
        end
      end
    end else begin
      // Offset 1 is the port right after the last grant; offset NUM_PORTS is the last grant itself.
      for (int k = NUM_PORTS; k >= 1; k--) begin
        idx = wrap_index(int'(last_grant), k, NUM_PORTS);
        if (request[idx]) begin
          winner = ID_W'(idx);
        end
      end
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// N-port block-transfer arbiter sharing one DRAM controller port.
// Latency: request seen in IDLE -> dram_request next cycle; dram_acknowledge -> port_acknowledge next cycle.
// Backpressure: one transfer in flight; other requesters hold their level request until acknowledged.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int        NUM_PORTS   = 2,
  parameter int        ADDR_W      = DEF_ADDR_W,
  parameter int        WORD_W      = DEF_WORD_W,
  parameter int        BLOCK_WORDS = DEF_BLOCK_WORDS,
  parameter arb_mode_e ARB_MODE    = ARB_RR
) (
  input  logic                                              clock,
  input  logic                                              reset,
  input  logic [NUM_PORTS-1:0]                              port_request,
  input  logic [NUM_PORTS-1:0]                              port_we,
  input  logic [NUM_PORTS-1:0][ADDR_W-1:0]                  port_address,
  input  logic [NUM_PORTS-1:0][BLOCK_WORDS-1:0][WORD_W-1:0] port_write_data,
  output logic [BLOCK_WORDS-1:0][WORD_W-1:0]                port_read_data,
  output logic [NUM_PORTS-1:0]                              port_acknowledge,
  output logic                                              dram_request,
  output logic                                              dram_we,
  output logic [ADDR_W-1:0]                                 dram_address,
  output logic [BLOCK_WORDS-1:0][WORD_W-1:0]                dram_write_data,
  input  logic [BLOCK_WORDS-1:0][WORD_W-1:0]                dram_read_data,
  input  logic                                              dram_acknowledge,
  output logic [$clog2(NUM_PORTS)-1:0]                      grant_id,
  output logic                                              busy
);

  localparam int ID_W = $clog2(NUM_PORTS);

  arb_state_e      state;
  logic [ID_W-1:0] last_grant;
  logic [ID_W-1:0] pick_id;
  logic            pick_vld;

  rr_pick #(
    .NUM_PORTS (NUM_PORTS)
  ) u_rr_pick (
    .request    (port_request),
    .last_grant (last_grant),
    .mode       (ARB_MODE),
    .winner     (pick_id),
    .valid      (pick_vld)
  );

  // Busy tracks the state register directly so an asynchronous reset clears it at once.
  assign busy = (state != IDLE);

  // Transfer sequencer: grant and capture in IDLE, hold the DRAM request in XFER, pulse ack in RESP.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state            <= IDLE;
      last_grant       <= ID_W'(NUM_PORTS - 1);
      grant_id         <= '0;
      dram_request     <= 1'b0;
      dram_we          <= 1'b0;
      dram_address     <= '0;
      dram_write_data  <= '0;
      port_read_data   <= '0;
      port_acknowledge <= '0;
    end else begin
      port_acknowledge <= '0;
      case (state)
        IDLE: begin
          if (pick_vld) begin
            grant_id        <= pick_id;
            if (ARB_MODE == ARB_RR) begin
              last_grant <= pick_id;
            end
            // The winner's command is frozen here; later changes at the port are not seen.
            dram_address    <= port_address[pick_id];
            dram_we         <= port_we[pick_id];
            dram_write_data <= port_write_data[pick_id];
            dram_request    <= 1'b1;
            state           <= XFER;
          end
        end
        XFER: begin
          if (dram_acknowledge) begin
            // Captured on writes too; the requester ignores it for write acknowledges.
            port_read_data             <= dram_read_data;
            dram_request               <= 1'b0;
            port_acknowledge[grant_id] <= 1'b1;
            state                      <= RESP;
          end
        end
        RESP: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Parametrised N-port block-transfer arbiter in front of the single DRAM port of the memory subsystem, generalising the fixed two-port icache/dcache sharing. Each port issues whole-block read or write requests. The arbiter grants one port at a time, in round-robin or fixed-priority order, and forwards the transaction to the DRAM controller. It then returns the read block and a one-cycle acknowledge to the granted port.

## Interface
Parameters:
- NUM_PORTS, 2: number of requesting ports (≥2).
- ADDR_W, 32: block address width (`DRAM_ADDRESS_SIZE).
- WORD_W, 32: word width (`DRAM_WORD_SIZE).
- BLOCK_WORDS, 4: words per block (`DRAM_BLOCK_SIZE).
- ARB_MODE, ARB_RR: arbitration policy.
  - ARB_RR: round-robin.
  - ARB_FIXED: lowest index wins.

Ports:
- clock, in, 1: single clock; all logic rising-edge.
- reset, in, 1: asynchronous, active-low reset.
- port_request, in, NUM_PORTS: per-port request, level; held until that port's acknowledge.
- port_we, in, NUM_PORTS: 1 = block write, 0 = block read.
- port_address, in, [NUM_PORTS][ADDR_W]: block address.
- port_write_data, in, [NUM_PORTS][BLOCK_WORDS][WORD_W]: write block.
- port_read_data, out, [BLOCK_WORDS][WORD_W]: shared read block bus.
- port_acknowledge, out, NUM_PORTS: one-hot, one-cycle completion pulse.
- dram_request, out, 1: request to DRAM controller.
- dram_we, out, 1: write enable to DRAM controller.
- dram_address, out, ADDR_W: address to DRAM controller.
- dram_write_data, out, [BLOCK_WORDS][WORD_W]: write block to DRAM controller.
- dram_read_data, in, [BLOCK_WORDS][WORD_W]: read block from DRAM controller.
- dram_acknowledge, in, 1: one-cycle completion pulse from DRAM controller.
- grant_id, out, $clog2(NUM_PORTS): index of the current or last granted port.
- busy, out, 1: high whenever state ≠ IDLE.

## Operation
- FSM states: IDLE, XFER, RESP.
- IDLE:
  - If port_request ≠ 0, pick a winner, register grant_id, and register the winner's address, we and write data into the dram_* output registers. Go to XFER.
  - Otherwise stay in IDLE.
- XFER:
  - dram_request = 1.
  - dram_address, dram_we and dram_write_data are stable for the whole state.
  - On dram_acknowledge: capture dram_read_data into port_read_data (also on writes), drop dram_request next cycle, go to RESP.
- RESP:
  - port_acknowledge[grant_id] = 1 for exactly this cycle. No arbitration in this state.
  - Go to IDLE.
- Arbitration in ARB_RR:
  - Search starts at (last_grant + 1) mod NUM_PORTS and wraps.
  - last_grant updates on every grant.
  - last_grant resets to NUM_PORTS−1, so port 0 wins first.
- Arbitration in ARB_FIXED: lowest set index wins. last_grant is unused.
- A request still high in the cycle after its acknowledge is treated as a new transaction.
- Requester drops request or changes address/data while in XFER: captured values are used; the transaction completes and is acknowledged normally.
- port_read_data holds its value until the next capture. It is don't-care for write acknowledges.

## Timing
- Request sampled in IDLE at cycle t → dram_request = 1 at t+1.
- dram_acknowledge at cycle k → port_acknowledge at k+1 and dram_request = 0 at k+1 → IDLE at k+2.
- Minimum request-to-acknowledge latency is 2 cycles (dram_acknowledge at t+1). A new grant is possible at k+2.
- Reset values:
  - state = IDLE.
  - dram_request, dram_we, busy = 0.
  - port_acknowledge = 0.
  - dram_address, dram_write_data, port_read_data = 0.
  - grant_id = 0.
  - last_grant = NUM_PORTS−1.
- Reset asserted mid-XFER: all outputs clear immediately and asynchronously; the transaction is abandoned. The DRAM controller shares the same reset.
- dram_acknowledge outside XFER is ignored.

## Structure
- Package mem_arb_pkg holds:
  - state enum {IDLE, XFER, RESP};
  - ARB_RR/ARB_FIXED mode constants;
  - block_t typedef (logic [BLOCK_WORDS-1:0][WORD_W-1:0]).
- Sub-module rr_pick: combinational winner selection.
  - Inputs: request vector, last_grant, mode.
  - Outputs: winner index and valid.
  - Instantiated once.

## Test plan
- Single read: port 1 reads 0x40; DRAM acknowledges 3 cycles later with {1,2,3,4}.
  - Expect dram_address = 0x40, dram_we = 0.
  - Expect port_acknowledge = 2'b10 one cycle after dram_acknowledge, with port_read_data = {1,2,3,4}.
- Round-robin fairness: NUM_PORTS = 4, all ports request continuously with 1-cycle DRAM acknowledge.
  - Expect grant order 0,1,2,3,0, one acknowledge every 3 cycles.
- Fixed priority: ARB_FIXED, ports 0 and 2 request continuously. Expect port 0 granted on every transaction.
- Write path: port 0 writes block {A,B,C,D} to 0x80.
  - Expect dram_we = 1 and dram_write_data = {A,B,C,D} stable through XFER.
  - Expect one acknowledge pulse.
- Simultaneous events: port 1 raises its request while port 0 is in XFER.
  - Expect no preemption; port 1 granted 2 cycles after port 0's dram_acknowledge.
- Reset mid-XFER: assert reset (low) while dram_request = 1.
  - Expect dram_request = 0 and busy = 0 immediately, and no port_acknowledge.
  - After release, the first grant goes to port 0.
